// File: rtl/iram_arbiter.sv
// -----------------------------------------------------------------------------
// iram_arbiter
//
// Shares one single-port instruction SRAM between a CPU fetch port and a
// Wishbone classic slave. The CPU has priority by default; its grant is
// combinational and the fetched word is presented one cycle later. Wishbone
// accesses run through a two-state FSM (IDLE/ACK) and are acknowledged one
// cycle after acceptance. Accesses outside the RAM window are acknowledged
// with zero data without touching the SRAM and without arbitration.
//
// Optional feature: define IRAM_ARB_STARVE_GUARD_EN to add a starvation
// counter that forces a Wishbone grant after STARVE_LIMIT denied cycles.
// Without the macro, arbitration is strict CPU priority.
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, synchronous active-low reset
//   wbs_*                      Wishbone classic slave (stb/cyc/we/sel/dat/adr,
//                              ack/dat_o)
//   cpu_req_i, cpu_addr_i      CPU fetch request and byte address
//   cpu_gnt_o                  fetch grant (same cycle as request)
//   cpu_rvalid_o, cpu_rdata_o  fetched word, one cycle after the grant
//   ram_*                      single-port SRAM port (csb/web active-low)
// -----------------------------------------------------------------------------
module iram_arbiter #(
   parameter int          RAM_ADDR_WIDTH_WORDS = 9,
   parameter logic [31:0] BASE_ADDR            = 32'h3000_0000,
   parameter int          STARVE_LIMIT         = 8
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_ni,
   input  logic                            wbs_stb_i,
   input  logic                            wbs_cyc_i,
   input  logic                            wbs_we_i,
   input  logic [3:0]                      wbs_sel_i,
   input  logic [31:0]                     wbs_dat_i,
   input  logic [31:0]                     wbs_adr_i,
   output logic                            wbs_ack_o,
   output logic [31:0]                     wbs_dat_o,
   input  logic                            cpu_req_i,
   input  logic [31:0]                     cpu_addr_i,
   output logic                            cpu_gnt_o,
   output logic                            cpu_rvalid_o,
   output logic [31:0]                     cpu_rdata_o,
   output logic                            ram_csb0,
   output logic                            ram_web0,
   output logic [3:0]                      ram_wmask0,
   output logic [RAM_ADDR_WIDTH_WORDS-1:0] ram_addr0,
   output logic [31:0]                     ram_din0,
   input  logic [31:0]                     ram_dout0
);

   // Lowest byte-address bit above the RAM window.
   localparam int TAG_LO = RAM_ADDR_WIDTH_WORDS + 2;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } wb_state_t;

   wb_state_t state_q, state_d;

   logic wb_pend_p0;
   logic wb_hit_p0;
   logic wb_gnt_p0;
   logic wb_miss_p0;
   logic cpu_gnt_p0;
   logic starve_force_p0;
   logic vld_p1;
   logic wb_rd_p1;

   // Byte-offset bits and the CPU's out-of-window bits carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wbs_adr_i[1:0], cpu_addr_i[31:TAG_LO], cpu_addr_i[1:0]};

   // ---- stage p0: request decode and arbitration ----
   // A stb still high during ACK belongs to the cycle being acknowledged.
   assign wb_pend_p0 = wbs_cyc_i & wbs_stb_i & (state_q == IDLE);
   assign wb_hit_p0  = (wbs_adr_i[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);

`ifdef IRAM_ARB_STARVE_GUARD_EN
   localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q;

   assign starve_force_p0 = (starve_cnt_q >= LIMIT);

   // Counts denied hit cycles; saturates at LIMIT because the next pending
   // cycle is then granted, which clears it.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         starve_cnt_q <= '0;
      end else if (wb_gnt_p0) begin
         starve_cnt_q <= '0;
      end else if (wb_pend_p0 && wb_hit_p0 && !starve_force_p0) begin
         starve_cnt_q <= starve_cnt_q + 1'b1;
      end
   end
`else
   assign starve_force_p0 = 1'b0;
`endif

   // Reset gates every grant so the SRAM is idle while wb_rst_ni is low.
   assign wb_gnt_p0  = wb_rst_ni & wb_pend_p0 & wb_hit_p0 & (~cpu_req_i | starve_force_p0);
   assign wb_miss_p0 = wb_rst_ni & wb_pend_p0 & ~wb_hit_p0;
   assign cpu_gnt_p0 = wb_rst_ni & cpu_req_i & ~wb_gnt_p0;

   always_comb begin
      state_d    = state_q;
      ram_csb0   = 1'b1;
      ram_web0   = 1'b1;
      ram_wmask0 = 4'b0000;
      ram_addr0  = '0;
      ram_din0   = '0;

      case (state_q)
         IDLE:    if (wb_gnt_p0 || wb_miss_p0) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (wb_gnt_p0) begin
         ram_csb0  = 1'b0;
         ram_web0  = ~wbs_we_i;
         ram_addr0 = wbs_adr_i[TAG_LO-1:2];
         if (wbs_we_i) begin
            ram_wmask0 = wbs_sel_i;
            ram_din0   = wbs_dat_i;
         end
      end else if (cpu_gnt_p0) begin
         ram_csb0  = 1'b0;
         ram_addr0 = cpu_addr_i[TAG_LO-1:2];
      end
   end

   // ---- stage p1: SRAM data returns, ack / rvalid ----
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q  <= IDLE;
         vld_p1   <= 1'b0;
         wb_rd_p1 <= 1'b0;
      end else begin
         state_q  <= state_d;
         vld_p1   <= cpu_gnt_p0;
         wb_rd_p1 <= wb_gnt_p0 & ~wbs_we_i;
      end
   end

   // Outputs are also gated by reset so an in-flight ack/rvalid vanishes the
   // moment reset is asserted, not one edge later.
   assign cpu_gnt_o    = cpu_gnt_p0;
   assign cpu_rvalid_o = vld_p1 & wb_rst_ni;
   assign cpu_rdata_o  = cpu_rvalid_o ? ram_dout0 : 32'h0;
   assign wbs_ack_o    = (state_q == ACK) & wb_rst_ni;
   assign wbs_dat_o    = (wbs_ack_o & wb_rd_p1) ? ram_dout0 : 32'h0;

endmodule

// File: doc/iram_arbiter.md
IRAM_ARBITER -- requirements
Module: iram_arbiter

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH_WORDS, default 9, giving the SRAM word-address width (512 words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, giving the Wishbone base address of the instruction RAM.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, giving the number of consecutive denied Wishbone cycles before a forced Wishbone grant.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port wb_rst_ni  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave strobe, cycle and write-enable.
REQ-007 SHALL have ports wbs_sel_i  in  4, wbs_dat_i  in  32 and wbs_adr_i  in  32  Wishbone byte select, write data and byte address.
REQ-008 SHALL have ports wbs_ack_o  out  1 and wbs_dat_o  out  32  Wishbone acknowledge and read data.
REQ-009 SHALL have ports cpu_req_i  in  1 and cpu_addr_i  in  32  CPU fetch request and byte address.
REQ-010 SHALL have ports cpu_gnt_o  out  1, cpu_rvalid_o  out  1 and cpu_rdata_o  out  32  fetch grant, read-valid and instruction word.
REQ-011 SHALL have ports ram_csb0, ram_web0  out  1 each (active-low), ram_wmask0  out  4, ram_addr0  out  RAM_ADDR_WIDTH_WORDS, ram_din0  out  32 and ram_dout0  in  32  single-port SRAM access.

Function
REQ-012 SHALL issue at most one SRAM access per cycle; ram_csb0=0 only in a cycle where a requester is granted, else ram_csb0=1, ram_web0=1, ram_wmask0=0.
REQ-013 SHALL consider a Wishbone request pending when wbs_cyc_i & wbs_stb_i = 1 and the FSM is in IDLE.
REQ-014 SHALL treat a Wishbone access as hit when wbs_adr_i[31:RAM_ADDR_WIDTH_WORDS+2] equals the same bits of BASE_ADDR; ram_addr0 = wbs_adr_i[RAM_ADDR_WIDTH_WORDS+1:2].
REQ-015 SHALL acknowledge a Wishbone miss one cycle after acceptance with wbs_dat_o=0, without touching the SRAM and without arbitrating against the CPU.
REQ-016 SHALL, for the CPU, drive ram_addr0 = cpu_addr_i[RAM_ADDR_WIDTH_WORDS+1:2] with ram_web0=1; the upper address bits are ignored.
REQ-017 SHALL default to CPU priority: when both requests are pending, the CPU is granted.
REQ-018 SHALL assert cpu_gnt_o combinationally in the grant cycle N, then cpu_rvalid_o=1 with cpu_rdata_o=ram_dout0 in cycle N+1.
REQ-019 SHALL drive cpu_rdata_o=0 whenever cpu_rvalid_o=0.
REQ-020 SHALL support back-to-back CPU grants, one per cycle, at full throughput.
REQ-021 SHALL implement a Wishbone FSM with states IDLE and ACK; IDLE->ACK on a Wishbone grant or miss acceptance, and ACK->IDLE unconditionally after one cycle.
REQ-022 SHALL drive wbs_ack_o=1 only in the ACK state (exactly one cycle), and SHALL treat a stb still high in ACK as not pending.
REQ-023 SHALL, on a Wishbone write grant, drive ram_web0=0, ram_wmask0=wbs_sel_i and ram_din0=wbs_dat_i; on a read, ram_web0=1 and ram_wmask0=0.
REQ-024 SHALL drive wbs_dat_o=ram_dout0 in ACK after a hit read, and 0 otherwise.
REQ-025 SHALL allow the SRAM port, while the FSM is in ACK, to serve a CPU request in the same cycle.
REQ-026 SHALL ignore a Wishbone request that deasserts before its grant; nothing is issued.
REQ-027 SHALL maintain the starvation counter per the Configuration section.

Reset
REQ-028 SHALL, while wb_rst_ni=0 at a clock edge, set FSM=IDLE, starvation counter=0, wbs_ack_o=0, wbs_dat_o=0, cpu_rvalid_o=0 and cpu_rdata_o=0.
REQ-029 SHALL, while wb_rst_ni=0, combinationally force cpu_gnt_o=0, ram_csb0=1, ram_web0=1 and ram_wmask0=0.
REQ-030 SHALL drop a pending ACK or rvalid when reset is asserted mid-operation; no late ack or rvalid appears after reset release.

Configuration
REQ-031 SHALL, with macro IRAM_ARB_STARVE_GUARD_EN defined, count cycles in which a Wishbone hit is pending but denied.
REQ-032 SHALL, when that count reaches STARVE_LIMIT and the macro is defined, grant Wishbone over the CPU in the next pending cycle, then clear the counter; any Wishbone grant also clears it.
REQ-033 SHALL, with IRAM_ARB_STARVE_GUARD_EN undefined, omit the counter and apply strict CPU priority, under which Wishbone may wait indefinitely.

Verification
REQ-034 SHALL cover: WB write adr=32'h3000_0010, dat=32'hDEAD_BEEF, sel=4'hF, then read back -> each acked one cycle after acceptance, read wbs_dat_o=32'hDEAD_BEEF, ram_addr0=4.
REQ-035 SHALL cover: WB write sel=4'b0011 -> ram_wmask0=4'b0011, ram_web0=0 for exactly one cycle.
REQ-036 SHALL cover: WB read adr=32'h3000_1000 (miss) -> ack next cycle, wbs_dat_o=0, ram_csb0 stays 1.
REQ-037 SHALL cover: cpu_req_i held high for 5 cycles, addresses 0,4,8,12,16 -> 5 grants, rvalid each following cycle, rdata matching preloaded words.
REQ-038 SHALL cover: cpu_req_i held high with WB pending -> macro defined: WB granted on the 9th pending cycle, ack on the 10th, cpu_gnt_o=0 in the WB grant cycle; macro undefined: no ack while the CPU requests.
REQ-039 SHALL cover: wb_rst_ni=0 in the cycle after a WB grant -> no wbs_ack_o; after release, FSM=IDLE and all outputs at reset values.
